// File: rtl/cpu_defs_pkg.sv
// Shared LA32R types and constants for the address translation path.
package cpu_defs;

    localparam int TLB_ENTRY_NUM = 16;

    typedef enum logic [1:0] {
        LOOKUP_FETCH = 2'd0,
        LOOKUP_LOAD  = 2'd1,
        LOOKUP_STORE = 2'd2
    } lookup_t;

    typedef enum logic [1:0] {
        BYTE      = 2'd0,
        HALF_WORD = 2'd1,
        WORD      = 2'd2
    } byte_type_t;

    typedef logic [1:0]  mat_t;
    typedef logic [31:0] phy_t;

    localparam logic [5:0] ECODE_PIL  = 6'h01;
    localparam logic [5:0] ECODE_PIS  = 6'h02;
    localparam logic [5:0] ECODE_PIF  = 6'h03;
    localparam logic [5:0] ECODE_PME  = 6'h04;
    localparam logic [5:0] ECODE_PPI  = 6'h07;
    localparam logic [5:0] ECODE_ADE  = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_TLBR = 6'h3F;

    typedef struct packed {
        logic        valid;
        logic [14:0] esubcode_ecode;
        logic [31:0] badv;
    } excp_pass_t;

    typedef struct packed {
        logic        v;
        logic        d;
        mat_t        mat;
        logic [1:0]  plv;
        logic [19:0] ppn;
    } tlb_page_t;

    typedef struct packed {
        logic        e;
        logic [9:0]  asid;
        logic        g;
        logic [5:0]  ps;
        logic [18:0] vppn;
        tlb_page_t   p0;
        tlb_page_t   p1;
    } tlb_entry_t;

    typedef struct packed {
        logic [1:0] datm;
        logic [1:0] datf;
        logic       pg;
        logic       da;
        logic [1:0] plv;
    } crmd_t;

    typedef struct packed {
        logic [9:0] asid;
    } asid_t;

    typedef struct packed {
        logic [2:0] vseg;
        logic [2:0] pseg;
        mat_t       mat;
        logic       plv3;
        logic       plv0;
    } dmw_t;

    typedef struct packed {
        crmd_t crmd;
        asid_t asid;
        dmw_t  dmw0;
        dmw_t  dmw1;
    } csr_t;

    // esubcode is always zero for the faults this port can raise
    function automatic logic [14:0] ecode_word(input logic [5:0] ecode);
        return {9'd0, ecode};
    endfunction

endpackage

// File: rtl/tlb_match.sv
// Single TLB entry compare: hit flag, odd-page select and page-size flag.
module tlb_match
    import cpu_defs::*;
(
    input  tlb_entry_t  entry,
    input  logic [31:12] va_hi,
    input  logic [9:0]  asid,
    output logic        hit,
    output logic        odd_sel,
    output logic        ps_huge
);

    logic is_4k;
    logic vpn_eq;

    always_comb begin
        is_4k   = (entry.ps == 6'd12);
        ps_huge = (entry.ps == 6'd21);
        vpn_eq  = 1'b0;
        if (is_4k) begin
            vpn_eq = (entry.vppn == va_hi[31:13]);
        end else if (ps_huge) begin
            vpn_eq = (entry.vppn[18:9] == va_hi[31:22]);
        end
        hit     = entry.e & (entry.g | (entry.asid == asid)) & vpn_eq;
        odd_sel = ps_huge ? va_hi[21] : va_hi[12];
    end

endmodule

// File: rtl/addr_trans.sv
// LA32R VA->PA translation (DA / DMW / TLB) with prioritised fault report.
// ADDR_TRANS_PERF_EN adds registered lookup and TLB-refill counters.
module addr_trans
    import cpu_defs::*;
#(
    parameter int TLB_ENTRY_NUM = cpu_defs::TLB_ENTRY_NUM
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [31:0] va,
    input  lookup_t    lookup_type,
    input  byte_type_t byte_type,
    input  csr_t       rd_csr,
    input  tlb_entry_t tlb_entrys [TLB_ENTRY_NUM],
    output mat_t       mat,
    output phy_t       pa,
    output excp_pass_t excp
`ifdef ADDR_TRANS_PERF_EN
    ,
    output logic [31:0] perf_lookup_cnt,
    output logic [31:0] perf_tlbr_cnt
`endif
);

    logic [TLB_ENTRY_NUM-1:0] hit_vec;
    logic [TLB_ENTRY_NUM-1:0] odd_vec;
    logic [TLB_ENTRY_NUM-1:0] huge_vec;

    for (genvar i = 0; i < TLB_ENTRY_NUM; i++) begin : g_match
        tlb_match u_match (
            .entry   (tlb_entrys[i]),
            .va_hi   (va[31:12]),
            .asid    (rd_csr.asid.asid),
            .hit     (hit_vec[i]),
            .odd_sel (odd_vec[i]),
            .ps_huge (huge_vec[i])
        );
    end

    logic      direct;
    logic      is_fetch;
    logic      is_store;
    logic      dmw0_hit;
    logic      dmw1_hit;
    logic      tlb_path;
    logic      tlb_hit;
    logic      sel_huge;
    tlb_page_t sel_page;
    logic      misalign;
    logic      fault;
    logic      tlbr;
    logic [5:0] ecode;

    always_comb begin
        direct   = rd_csr.crmd.da & ~rd_csr.crmd.pg;
        is_fetch = (lookup_type == LOOKUP_FETCH);
        is_store = (lookup_type == LOOKUP_STORE);

        dmw0_hit = (va[31:29] == rd_csr.dmw0.vseg) &
                   (((rd_csr.crmd.plv == 2'd0) & rd_csr.dmw0.plv0) |
                    ((rd_csr.crmd.plv == 2'd3) & rd_csr.dmw0.plv3));
        dmw1_hit = (va[31:29] == rd_csr.dmw1.vseg) &
                   (((rd_csr.crmd.plv == 2'd0) & rd_csr.dmw1.plv0) |
                    ((rd_csr.crmd.plv == 2'd3) & rd_csr.dmw1.plv3));
        tlb_path = ~direct & ~dmw0_hit & ~dmw1_hit;

        // Walk from the top so the lowest matching index is the one kept
        tlb_hit  = 1'b0;
        sel_huge = 1'b0;
        sel_page = '0;
        for (int i = TLB_ENTRY_NUM - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                tlb_hit  = 1'b1;
                sel_huge = huge_vec[i];
                sel_page = odd_vec[i] ? tlb_entrys[i].p1 : tlb_entrys[i].p0;
            end
        end

        if (direct) begin
            pa  = va;
            mat = is_fetch ? rd_csr.crmd.datf : rd_csr.crmd.datm;
        end else if (dmw0_hit) begin
            pa  = {rd_csr.dmw0.pseg, va[28:0]};
            mat = rd_csr.dmw0.mat;
        end else if (dmw1_hit) begin
            pa  = {rd_csr.dmw1.pseg, va[28:0]};
            mat = rd_csr.dmw1.mat;
        end else if (tlb_hit) begin
            pa  = sel_huge ? {sel_page.ppn[19:9], va[20:0]} : {sel_page.ppn, va[11:0]};
            mat = sel_page.mat;
        end else begin
            pa  = va;
            mat = 2'b00;
        end

        case (byte_type)
            HALF_WORD: misalign = va[0];
            WORD:      misalign = (va[1:0] != 2'b00);
            default:   misalign = 1'b0;
        endcase

        tlbr  = 1'b0;
        ecode = 6'd0;
        if (is_fetch && va[1:0] != 2'b00) begin
            ecode = ECODE_ADE;
        end else if (!is_fetch && misalign) begin
            ecode = ECODE_ALE;
        end else if (tlb_path) begin
            if (!tlb_hit) begin
                tlbr  = 1'b1;
                ecode = ECODE_TLBR;
            end else if (!sel_page.v) begin
                ecode = is_fetch ? ECODE_PIF : (is_store ? ECODE_PIS : ECODE_PIL);
            end else if (rd_csr.crmd.plv > sel_page.plv) begin
                ecode = ECODE_PPI;
            end else if (is_store && !sel_page.d) begin
                ecode = ECODE_PME;
            end
        end
        fault = (ecode != 6'd0);

        excp.valid          = en & fault;
        excp.esubcode_ecode = ecode_word(ecode);
        excp.badv           = va;
    end

`ifdef ADDR_TRANS_PERF_EN
    logic [31:0] lookup_cnt_q, lookup_cnt_d;
    logic [31:0] tlbr_cnt_q,   tlbr_cnt_d;

    always_comb begin
        lookup_cnt_d = lookup_cnt_q + {31'd0, en & tlb_path};
        tlbr_cnt_d   = tlbr_cnt_q   + {31'd0, en & tlbr};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lookup_cnt_q <= '0;
            tlbr_cnt_q   <= '0;
        end else begin
            lookup_cnt_q <= lookup_cnt_d;
            tlbr_cnt_q   <= tlbr_cnt_d;
        end
    end

    assign perf_lookup_cnt = lookup_cnt_q;
    assign perf_tlbr_cnt   = tlbr_cnt_q;
`else
    // Clock and reset only feed the optional counters
    logic unused_clk_rst;
    assign unused_clk_rst = &{1'b0, clk, rst, tlbr};
`endif

endmodule

// File: tb/tb_addr_trans.sv
// Scoreboard bench for addr_trans: directed cases plus randomized lookups.
module tb_addr_trans;
    import cpu_defs::*;

    localparam int N = TLB_ENTRY_NUM;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en;
    logic [31:0] va;
    lookup_t    lookup_type;
    byte_type_t byte_type;
    csr_t       rd_csr;
    tlb_entry_t tlb_entrys [N];
    mat_t       mat;
    phy_t       pa;
    excp_pass_t excp;
`ifdef ADDR_TRANS_PERF_EN
    logic [31:0] perf_lookup_cnt, perf_tlbr_cnt;
`endif

    addr_trans #(.TLB_ENTRY_NUM(N)) dut (
        .clk(clk), .rst(rst), .en(en), .va(va),
        .lookup_type(lookup_type), .byte_type(byte_type),
        .rd_csr(rd_csr), .tlb_entrys(tlb_entrys),
        .mat(mat), .pa(pa), .excp(excp)
`ifdef ADDR_TRANS_PERF_EN
        , .perf_lookup_cnt(perf_lookup_cnt), .perf_tlbr_cnt(perf_tlbr_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] pa;
        logic [1:0]  mat;
        logic        valid;
        logic [14:0] code;
        logic [31:0] badv;
        bit          chk_code;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: the translation is combinational, so every issued lookup is
    // presented by the next falling edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk({e.name, ".pa"},    pa,                {e.pa});
            chk({e.name, ".mat"},   {30'd0, mat},      {30'd0, e.mat});
            chk({e.name, ".valid"}, {31'd0, excp.valid}, {31'd0, e.valid});
            chk({e.name, ".badv"},  excp.badv,         e.badv);
            if (e.chk_code)
                chk({e.name, ".ecode"}, {17'd0, excp.esubcode_ecode}, {17'd0, e.code});
        end
    end

    // Reference model: rules applied with plain arithmetic on page sizes.
    function automatic exp_t model(input string name, input logic en_i,
                                   input logic [31:0] v, input int lt, input int bt);
        exp_t r;
        int ec;
        int sz;
        bit hit;
        bit dmw_hit;
        int ps;
        int hit_ps;
        tlb_page_t pg;
        logic [31:0] mask;
        r.name = name; r.badv = v; r.chk_code = 1; ec = 0;
        hit_ps = 12; pg = '0;
        if (lt == 0) begin
            if (v % 4 != 0) ec = 8;
        end else begin
            sz = (bt == 1) ? 2 : (bt == 2) ? 4 : 1;
            if (v % sz != 0) ec = 9;
        end
        if (rd_csr.crmd.da && !rd_csr.crmd.pg) begin
            r.pa = v;
            r.mat = (lt == 0) ? rd_csr.crmd.datf : rd_csr.crmd.datm;
        end else begin
            dmw_hit = 0;
            for (int k = 0; k < 2; k++) begin
                dmw_t d;
                d = (k == 0) ? rd_csr.dmw0 : rd_csr.dmw1;
                if (!dmw_hit && (v >> 29) == d.vseg &&
                    ((rd_csr.crmd.plv == 0 && d.plv0) || (rd_csr.crmd.plv == 3 && d.plv3))) begin
                    dmw_hit = 1;
                    r.pa = {d.pseg, 29'd0} | (v & 32'h1FFF_FFFF);
                    r.mat = d.mat;
                end
            end
            if (!dmw_hit) begin
                hit = 0;
                for (int i = 0; i < N; i++) begin
                    tlb_entry_t te;
                    te = tlb_entrys[i];
                    ps = int'(te.ps);
                    if (!hit && te.e && (te.g || te.asid == rd_csr.asid.asid) &&
                        (ps == 12 || ps == 21) &&
                        ((v >> (ps + 1)) == ({te.vppn, 13'd0} >> (ps + 1)))) begin
                        hit = 1;
                        hit_ps = ps;
                        pg = ((v >> ps) & 1) != 0 ? te.p1 : te.p0;
                    end
                end
                if (hit) begin
                    mask = (32'd1 << hit_ps) - 1;
                    r.pa = ({pg.ppn, 12'd0} & ~mask) | (v & mask);
                    r.mat = pg.mat;
                    if (ec == 0) begin
                        if (!pg.v) ec = (lt == 0) ? 3 : (lt == 1) ? 1 : 2;
                        else if (rd_csr.crmd.plv > pg.plv) ec = 7;
                        else if (lt == 2 && !pg.d) ec = 4;
                    end
                end else begin
                    r.pa = v;
                    r.mat = 2'b00;
                    if (ec == 0) ec = 63;
                end
            end
        end
        r.valid = en_i && (ec != 0);
        r.code = {9'd0, 6'(ec)};
        return r;
    endfunction

    task automatic apply(input logic en_i, input logic [31:0] v, input int lt, input int bt);
        @(posedge clk);
        #1;
        en = en_i; va = v;
        lookup_type = lookup_t'(lt[1:0]);
        byte_type = byte_type_t'(bt[1:0]);
    endtask

    task automatic finish_item();
        @(negedge clk);
        #1;
    endtask

    // Directed item: expected values are given literally
    task automatic drive_exp(input string name, input logic en_i, input logic [31:0] v,
                             input int lt, input int bt, input logic [31:0] e_pa,
                             input logic [1:0] e_mat, input logic e_valid,
                             input logic [5:0] e_code, input bit chk_code);
        exp_t e;
        apply(en_i, v, lt, bt);
        e.name = name; e.pa = e_pa; e.mat = e_mat; e.valid = e_valid;
        e.code = {9'd0, e_code}; e.badv = v; e.chk_code = chk_code;
        sb.push_back(e);
        finish_item();
    endtask

    task automatic drive_rand(input string name, input logic en_i, input logic [31:0] v,
                              input int lt, input int bt);
        apply(en_i, v, lt, bt);
        sb.push_back(model(name, en_i, v, lt, bt));
        finish_item();
    endtask

    function automatic tlb_page_t rnd_page();
        tlb_page_t p;
        p.v = ($urandom % 4) != 0;
        p.d = $urandom % 2;
        p.mat = 2'($urandom);
        p.plv = 2'($urandom);
        p.ppn = 20'($urandom);
        return p;
    endfunction

    logic [18:0] vppn_pool [4];

    function automatic tlb_entry_t rnd_entry();
        tlb_entry_t t;
        int pick;
        t.e = ($urandom % 4) != 0;
        t.asid = 10'($urandom_range(1, 2));
        t.g = ($urandom % 3) == 0;
        pick = $urandom % 4;
        t.ps = (pick == 3) ? 6'd13 : (pick == 2) ? 6'd21 : 6'd12;
        t.vppn = vppn_pool[$urandom % 4];
        t.p0 = rnd_page();
        t.p1 = rnd_page();
        return t;
    endfunction

    initial begin
        logic [31:0] v;
        en = 1'b0; va = '0; lookup_type = LOOKUP_LOAD; byte_type = WORD;
        rd_csr = '0;
        for (int i = 0; i < N; i++) tlb_entrys[i] = '0;
        #12;
`ifdef ADDR_TRANS_PERF_EN
        chk("reset.lookup_cnt", perf_lookup_cnt, 32'd0);
        chk("reset.tlbr_cnt", perf_tlbr_cnt, 32'd0);
`endif
        rst = 1'b0;
        // With all CSRs zero: mapped, plv0 DMW bits clear, empty TLB -> TLBR
        drive_exp("idle_en0", 1'b0, 32'h0000_0000, 1, 2, 32'h0, 2'b00, 1'b0, 6'h3F, 1);

        rd_csr.crmd.da = 1; rd_csr.crmd.pg = 0; rd_csr.crmd.datm = 2'd1; rd_csr.crmd.datf = 2'd0;
        drive_exp("da_load", 1'b1, 32'h1C00_0104, 1, 2, 32'h1C00_0104, 2'd1, 1'b0, 6'h00, 1);
        drive_exp("da_fetch", 1'b1, 32'h1C00_0104, 0, 2, 32'h1C00_0104, 2'd0, 1'b0, 6'h00, 1);
        drive_exp("da_ale", 1'b1, 32'h1C00_0102, 1, 2, 32'h1C00_0102, 2'd1, 1'b1, 6'h09, 1);

        rd_csr.crmd.da = 0; rd_csr.crmd.pg = 1; rd_csr.crmd.plv = 0;
        rd_csr.dmw0.vseg = 3'd5; rd_csr.dmw0.pseg = 3'd0; rd_csr.dmw0.plv0 = 1; rd_csr.dmw0.mat = 2'd1;
        drive_exp("dmw0", 1'b1, 32'hA000_1234, 1, 2, 32'h0000_1234, 2'd1, 1'b0, 6'h00, 1);
        rd_csr.dmw1.vseg = 3'd5; rd_csr.dmw1.pseg = 3'd7; rd_csr.dmw1.plv0 = 1; rd_csr.dmw1.mat = 2'd2;
        drive_exp("dmw0_wins", 1'b1, 32'hA000_1234, 1, 2, 32'h0000_1234, 2'd1, 1'b0, 6'h00, 1);
        rd_csr.dmw1 = '0;

        tlb_entrys[0].e = 1; tlb_entrys[0].vppn = 19'h12345; tlb_entrys[0].ps = 6'd12;
        tlb_entrys[0].g = 1;
        tlb_entrys[0].p1.ppn = 20'h00ABC; tlb_entrys[0].p1.v = 1; tlb_entrys[0].p1.d = 1;
        tlb_entrys[0].p1.mat = 2'd1;
        drive_exp("tlb4k", 1'b1, 32'h2468_B010, 1, 2, 32'h00AB_C010, 2'd1, 1'b0, 6'h00, 1);
        tlb_entrys[0].p1.d = 0;
        drive_exp("pme", 1'b1, 32'h2468_B010, 2, 2, 32'h00AB_C010, 2'd1, 1'b1, 6'h04, 1);
        tlb_entrys[0].p1.v = 0;
        drive_exp("pil", 1'b1, 32'h2468_B010, 1, 2, 32'h00AB_C010, 2'd1, 1'b1, 6'h01, 1);
        drive_exp("pif", 1'b1, 32'h2468_B010, 0, 2, 32'h00AB_C010, 2'd1, 1'b1, 6'h03, 1);
        tlb_entrys[0].p1.v = 1; tlb_entrys[0].p1.d = 1; rd_csr.crmd.plv = 2'd3;
        drive_exp("ppi", 1'b1, 32'h2468_B010, 1, 2, 32'h00AB_C010, 2'd1, 1'b1, 6'h07, 1);
        rd_csr.crmd.plv = 2'd0;
        drive_exp("tlbr", 1'b1, 32'h4000_0000, 1, 2, 32'h4000_0000, 2'd0, 1'b1, 6'h3F, 1);
        drive_exp("en0", 1'b0, 32'h4000_0000, 1, 2, 32'h4000_0000, 2'd0, 1'b0, 6'h00, 0);
        drive_exp("ale_over_tlbr", 1'b1, 32'h4000_0001, 2, 1, 32'h4000_0001, 2'd0, 1'b1, 6'h09, 1);
        drive_exp("adef", 1'b1, 32'h4000_0002, 0, 0, 32'h4000_0002, 2'd0, 1'b1, 6'h08, 1);
        drive_exp("byte_odd_ok", 1'b1, 32'h2468_B011, 1, 0, 32'h00AB_C011, 2'd1, 1'b0, 6'h00, 1);

`ifdef ADDR_TRANS_PERF_EN
        for (int i = 0; i < 2; i++)
            drive_exp("perf_pre", 1'b1, 32'h4000_0000, 1, 2, 32'h4000_0000, 2'd0, 1'b1, 6'h3F, 1);
        chk("perf.nonzero", {31'd0, perf_tlbr_cnt != 0}, 32'd1);
        rst = 1'b1;
        #1;
        chk("perf.rst_lookup", perf_lookup_cnt, 32'd0);
        chk("perf.rst_tlbr", perf_tlbr_cnt, 32'd0);
        en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++)
            drive_exp("perf_tlbr", 1'b1, 32'h4000_0000, 1, 2, 32'h4000_0000, 2'd0, 1'b1, 6'h3F, 1);
        drive_exp("perf_idle", 1'b0, 32'h4000_0000, 1, 2, 32'h4000_0000, 2'd0, 1'b0, 6'h00, 0);
        @(posedge clk);
        #1;
        chk("perf.tlbr_cnt", perf_tlbr_cnt, 32'd3);
        chk("perf.lookup_cnt", perf_lookup_cnt, 32'd3);
`endif

        for (int i = 0; i < 4; i++) vppn_pool[i] = 19'($urandom);
        for (int it = 0; it < 400; it++) begin
            int lt, bt, r;
            if (it % 25 == 0) begin
                for (int i = 0; i < N; i++) tlb_entrys[i] = rnd_entry();
                rd_csr.crmd = crmd_t'(8'($urandom));
                rd_csr.crmd.da = ($urandom % 5) == 0;
                rd_csr.crmd.pg = ~rd_csr.crmd.da;
                rd_csr.asid.asid = 10'($urandom_range(1, 2));
                rd_csr.dmw0 = dmw_t'(10'($urandom));
                rd_csr.dmw1 = dmw_t'(10'($urandom));
            end
            r = $urandom % 10;
            if (r < 6) begin
                tlb_entry_t te;
                logic [31:0] lowmask;
                te = tlb_entrys[$urandom % N];
                lowmask = (te.ps == 6'd21) ? 32'h003F_FFFF : 32'h0000_1FFF;
                v = ({te.vppn, 13'd0} & ~lowmask) | ($urandom & lowmask);
            end else begin
                v = $urandom;
            end
            if ($urandom % 2) v[1:0] = 2'b00;
            lt = $urandom_range(0, 2);
            bt = $urandom_range(0, 3);
            drive_rand("rand", ($urandom % 8) != 0, v, lt, bt);
        end

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            total++; bad++;
            $display("FAIL drain: %0d items left, expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
